gptp_rx_parser: RTL and testbench

Ingress frame parser that sits directly upstream of the gPTP receive block `rx`. It consumes the MAC receive byte stream of a gPTP Ethernet frame (EtherType 0x88F7) together with the ingress timestamp latched at start-of-frame. It extracts the message type, the header fields and the 80-bit body timestamp, and emits one 432-bit descriptor per accepted frame on the `gptp_rv_*` valid/ready interface. Frames that fail the checks are discarded and counted.

---
 rtl/gptp_rx_parser.sv | 152 +++++++++++++++
 tb/tb_gptp_rx_parser.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gptp_rx_parser.sv
// gptp_rx_parser
// Ingress parser for gPTP frames (EtherType 0x88F7). It walks the MAC
// receive byte stream, captures the header fields and body timestamp into a
// shadow register, and emits one 432-bit descriptor per accepted frame
// through a single-entry valid/ready output slot. gPTP-candidate frames that
// cannot be delivered (runt, MAC error, slot busy) are counted.
module gptp_rx_parser (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   mac_rx_data,
    input  logic         mac_rx_valid,
    input  logic         mac_rx_sof,
    input  logic         mac_rx_eof,
    input  logic         mac_rx_err,
    input  logic [79:0]  rx_ts,
    output logic [431:0] gptp_rv_data,
    output logic         gptp_rv_vaild,
    input  logic         gptp_rv_ready,
    output logic [15:0]  rx_drop_cnt
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PARSE   = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [1:0]   state_reg, state_next;
    logic [5:0]   cnt_reg, cnt_next;        // offset of the byte on the current beat
    logic [79:0]  ts_reg, ts_next;
    logic [7:0]   etype_hi_reg, etype_hi_next;
    logic [3:0]   type_reg, type_next;
    logic [63:0]  corr_reg, corr_next;
    logic [79:0]  port_reg, port_next;
    logic [15:0]  seq_reg, seq_next;
    logic [79:0]  body_reg, body_next;
    logic [431:0] desc_next;
    logic         hdr_bad;
    logic         accept;
    logic         drop;
    logic         slot_free;

    // The slot can take a new descriptor if empty or being drained this cycle.
    assign slot_free = !gptp_rv_vaild || gptp_rv_ready;

    // Next-state, field capture by byte offset, and commit decision.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        ts_next       = ts_reg;
        etype_hi_next = etype_hi_reg;
        type_next     = type_reg;
        corr_next     = corr_reg;
        port_next     = port_reg;
        seq_next      = seq_reg;
        body_next     = body_reg;
        hdr_bad       = 1'b0;
        accept        = 1'b0;
        drop          = 1'b0;

        if (mac_rx_valid) begin
            if (mac_rx_sof) begin
                // New frame: always restarts parsing, aborting any frame in flight.
                state_next    = S_PARSE;
                cnt_next      = 6'd1;
                ts_next       = rx_ts;
                etype_hi_next = 8'd0;
                type_next     = 4'd0;
                corr_next     = 64'd0;
                port_next     = 80'd0;
                seq_next      = 16'd0;
                body_next     = 80'd0;
                if (mac_rx_eof) begin
                    // Single-byte frame is a runt.
                    state_next = S_IDLE;
                    drop       = 1'b1;
                end
            end else if (state_reg == S_PARSE) begin
                cnt_next = (cnt_reg == 6'd63) ? cnt_reg : cnt_reg + 6'd1;
                if (cnt_reg == 6'd12) etype_hi_next = mac_rx_data;
                if (cnt_reg == 6'd14) type_next = mac_rx_data[3:0];
                if (cnt_reg >= 6'd22 && cnt_reg <= 6'd29) corr_next = {corr_reg[55:0], mac_rx_data};
                if (cnt_reg >= 6'd34 && cnt_reg <= 6'd43) port_next = {port_reg[71:0], mac_rx_data};
                if (cnt_reg >= 6'd44 && cnt_reg <= 6'd45) seq_next  = {seq_reg[7:0], mac_rx_data};
                if (cnt_reg >= 6'd48 && cnt_reg <= 6'd57) body_next = {body_reg[71:0], mac_rx_data};
                hdr_bad = ((cnt_reg == 6'd13) && ({etype_hi_reg, mac_rx_data} != 16'h88F7)) ||
                          ((cnt_reg == 6'd15) && (mac_rx_data[3:0] != 4'h2));
                if (mac_rx_eof) begin
                    state_next = S_IDLE;
                    // Non-gPTP frames ending on the check byte are silently ignored.
                    if (!hdr_bad) begin
                        if (cnt_reg >= 6'd57 && !mac_rx_err && slot_free)
                            accept = 1'b1;
                        else
                            drop = 1'b1;
                    end
                end else if (hdr_bad) begin
                    state_next = S_DISCARD;
                end
            end else if (state_reg == S_DISCARD) begin
                if (mac_rx_eof) state_next = S_IDLE;
            end
        end

        desc_next = {ts_next, seq_next, port_next, corr_next, 108'd0, type_next, body_next};
    end

    // Parser state and shadow register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= 6'd0;
            ts_reg       <= 80'd0;
            etype_hi_reg <= 8'd0;
            type_reg     <= 4'd0;
            corr_reg     <= 64'd0;
            port_reg     <= 80'd0;
            seq_reg      <= 16'd0;
            body_reg     <= 80'd0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            ts_reg       <= ts_next;
            etype_hi_reg <= etype_hi_next;
            type_reg     <= type_next;
            corr_reg     <= corr_next;
            port_reg     <= port_next;
            seq_reg      <= seq_next;
            body_reg     <= body_next;
        end
    end

    // Output slot: load on commit, release on handshake, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gptp_rv_vaild <= 1'b0;
            gptp_rv_data  <= 432'd0;
        end else if (accept) begin
            gptp_rv_vaild <= 1'b1;
            gptp_rv_data  <= desc_next;
        end else if (gptp_rv_vaild && gptp_rv_ready) begin
            gptp_rv_vaild <= 1'b0;
        end
    end

    // Discard counter for gPTP-candidate frames; wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rx_drop_cnt <= 16'd0;
        else if (drop)
            rx_drop_cnt <= rx_drop_cnt + 16'd1;
    end

endmodule

// File: tb/tb_gptp_rx_parser.sv
// Testbench for gptp_rx_parser: frames are synthesised byte by byte, expected
// descriptors go into a scoreboard queue, and a monitor compares every
// handshaked descriptor against the head of the queue.
module tb_gptp_rx_parser;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   mac_rx_data;
    logic         mac_rx_valid;
    logic         mac_rx_sof;
    logic         mac_rx_eof;
    logic         mac_rx_err;
    logic [79:0]  rx_ts;
    logic [431:0] gptp_rv_data;
    logic         gptp_rv_vaild;
    logic         gptp_rv_ready;
    logic [15:0]  rx_drop_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int rx_count  = 0;
    logic [431:0] exp_q[$];
    logic [7:0]   fb [0:63];

    always #5 clk = ~clk;

    gptp_rx_parser dut (
        .clk           (clk),
        .reset         (reset),
        .mac_rx_data   (mac_rx_data),
        .mac_rx_valid  (mac_rx_valid),
        .mac_rx_sof    (mac_rx_sof),
        .mac_rx_eof    (mac_rx_eof),
        .mac_rx_err    (mac_rx_err),
        .rx_ts         (rx_ts),
        .gptp_rv_data  (gptp_rv_data),
        .gptp_rv_vaild (gptp_rv_vaild),
        .gptp_rv_ready (gptp_rv_ready),
        .rx_drop_cnt   (rx_drop_cnt)
    );

    // Scoreboard monitor: a handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (!reset && gptp_rv_vaild && gptp_rv_ready) begin
            logic [431:0] e;
            total_cnt++;
            rx_count++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_desc got=%h required=none", gptp_rv_data);
            end else begin
                e = exp_q.pop_front();
                if (gptp_rv_data !== e)
                    $display("FAIL desc_data got=%h required=%h", gptp_rv_data, e);
                else begin
                    pass_cnt++;
                    $display("desc %0d ok seq=%h type=%h", rx_count, gptp_rv_data[351:336], gptp_rv_data[83:80]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [79:0] rnd80();
        return {16'($urandom), $urandom, $urandom};
    endfunction

    function automatic logic [431:0] mk_desc(input logic [79:0] ts, input logic [15:0] seq,
                                             input logic [79:0] port, input logic [63:0] corr,
                                             input logic [3:0] mt, input logic [79:0] body);
        return {ts, seq, port, corr, 108'd0, mt, body};
    endfunction

    task automatic build(input logic [15:0] etype, input logic [3:0] mt, input logic [3:0] ver,
                         input logic [63:0] corr, input logic [79:0] port,
                         input logic [15:0] seq, input logic [79:0] body);
        for (int i = 0; i < 64; i++) fb[i] = 8'($urandom);
        fb[12] = etype[15:8];
        fb[13] = etype[7:0];
        fb[14] = {fb[14][7:4], mt};
        fb[15] = {fb[15][7:4], ver};
        for (int k = 0; k < 8; k++)  fb[22+k] = corr[63-8*k -: 8];
        for (int k = 0; k < 10; k++) fb[34+k] = port[79-8*k -: 8];
        fb[44] = seq[15:8];
        fb[45] = seq[7:0];
        for (int k = 0; k < 10; k++) fb[48+k] = body[79-8*k -: 8];
    endtask

    // Build a well-formed gPTP frame with random fields; return its descriptor.
    task automatic good_frame(input logic [79:0] ts, input logic [3:0] mt, output logic [431:0] d);
        logic [63:0] corr;
        logic [79:0] port, body;
        logic [15:0] seq;
        corr = {$urandom, $urandom};
        port = rnd80();
        body = rnd80();
        seq  = 16'($urandom);
        build(16'h88F7, mt, 4'h2, corr, port, seq, body);
        d = mk_desc(ts, seq, port, corr, mt, body);
    endtask

    task automatic drive(input int len, input logic [79:0] ts, input bit err, input bit gaps,
                         input bit no_eof, input bit ready_on_eof);
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            if (gaps && $urandom_range(0, 3) == 0) begin
                mac_rx_valid = 1'b0;
                @(posedge clk); #1;
            end
            mac_rx_valid = 1'b1;
            mac_rx_data  = fb[i];
            mac_rx_sof   = (i == 0);
            mac_rx_eof   = (i == len - 1) && !no_eof;
            mac_rx_err   = mac_rx_eof && err;
            rx_ts        = (i == 0) ? ts : rnd80();
            if (mac_rx_eof && ready_on_eof) gptp_rv_ready = 1'b1;
        end
        @(posedge clk); #1;
        mac_rx_valid = 1'b0;
        mac_rx_sof   = 1'b0;
        mac_rx_eof   = 1'b0;
        mac_rx_err   = 1'b0;
        if (ready_on_eof) gptp_rv_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mac_rx_valid = 0; mac_rx_sof = 0; mac_rx_eof = 0; mac_rx_err = 0;
        mac_rx_data = 0; rx_ts = 0; gptp_rv_ready = 0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (gptp_rv_vaild !== 1'b0) $display("FAIL reset_valid got=%b required=0", gptp_rv_vaild); else pass_cnt++;
        total_cnt++;
        if (gptp_rv_data !== 432'd0) $display("FAIL reset_data got=%h required=0", gptp_rv_data); else pass_cnt++;
        total_cnt++;
        if (rx_drop_cnt !== 16'd0) $display("FAIL reset_drop got=%0d required=0", rx_drop_cnt); else pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_pdelay_req();
        logic [63:0] corr;
        logic [79:0] port;
        logic [15:0] seq;
        corr = 64'h0000_0000_0001_8000;
        port = 80'h0011_22ff_fe33_4455_0001;
        seq  = 16'h1234;
        build(16'h88F7, 4'h2, 4'h2, corr, port, seq, 80'h123456789abc00000001);
        exp_q.push_back(mk_desc(80'h123456789abc00000002, seq, port, corr, 4'h2, 80'h123456789abc00000001));
        gptp_rv_ready = 1'b0;
        drive(58, 80'h123456789abc00000002, 0, 0, 0, 0);
        @(negedge clk);
        total_cnt++;
        if (gptp_rv_vaild !== 1'b1) $display("FAIL pdelay_valid got=%b required=1", gptp_rv_vaild); else pass_cnt++;
        @(posedge clk); #1;
        gptp_rv_ready = 1'b1;
        @(posedge clk); #1;
        gptp_rv_ready = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (gptp_rv_vaild !== 1'b0) $display("FAIL pdelay_valid_drop got=%b required=0", gptp_rv_vaild); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [431:0] d;
        int rx0;
        rx0 = rx_count;
        gptp_rv_ready = 1'b1;
        good_frame(rnd80(), 4'h3, d);
        exp_q.push_back(d);
        drive(60, d[431:352], 0, 0, 0, 0);
        idle(12);
        good_frame(rnd80(), 4'h3, d);
        exp_q.push_back(d);
        drive(64, d[431:352], 0, 0, 0, 0);
        idle(4);
        total_cnt++;
        if (rx_count - rx0 !== 2) $display("FAIL b2b_count got=%0d required=2", rx_count - rx0); else pass_cnt++;
        total_cnt++;
        if (rx_drop_cnt !== 16'd0) $display("FAIL b2b_drop got=%0d required=0", rx_drop_cnt); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [431:0] da, db;
        gptp_rv_ready = 1'b0;
        good_frame(rnd80(), 4'h0, da);
        exp_q.push_back(da);
        drive(58, da[431:352], 0, 1, 0, 0);
        good_frame(rnd80(), 4'h1, db);
        drive(62, db[431:352], 0, 1, 0, 0);
        @(negedge clk);
        total_cnt++;
        if (rx_drop_cnt !== 16'd1) $display("FAIL bp_drop got=%0d required=1", rx_drop_cnt); else pass_cnt++;
        total_cnt++;
        if (gptp_rv_data !== da) $display("FAIL bp_data_hold got=%h required=%h", gptp_rv_data, da); else pass_cnt++;
        @(posedge clk); #1;
        gptp_rv_ready = 1'b1;
        @(posedge clk); #1;
        gptp_rv_ready = 1'b0;
        // Second round: ready arrives on B's eof beat, so B replaces A.
        good_frame(rnd80(), 4'h8, da);
        exp_q.push_back(da);
        drive(58, da[431:352], 0, 0, 0, 0);
        good_frame(rnd80(), 4'h9, db);
        exp_q.push_back(db);
        drive(58, db[431:352], 0, 1, 0, 1);
        @(negedge clk);
        total_cnt++;
        if (gptp_rv_vaild !== 1'b1) $display("FAIL bp_valid_stay got=%b required=1", gptp_rv_vaild); else pass_cnt++;
        total_cnt++;
        if (gptp_rv_data !== db) $display("FAIL bp_data_new got=%h required=%h", gptp_rv_data, db); else pass_cnt++;
        total_cnt++;
        if (rx_drop_cnt !== 16'd1) $display("FAIL bp_drop2 got=%0d required=1", rx_drop_cnt); else pass_cnt++;
        @(posedge clk); #1;
        gptp_rv_ready = 1'b1;
        @(posedge clk); #1;
        gptp_rv_ready = 1'b0;
    endtask

    task automatic test_bad_frames();
        int rx0;
        rx0 = rx_count;
        gptp_rv_ready = 1'b1;
        build(16'h0800, 4'h2, 4'h2, 64'd5, rnd80(), 16'd7, rnd80());
        drive(60, rnd80(), 0, 0, 0, 0);
        @(negedge clk);
        total_cnt++;
        if (rx_drop_cnt !== 16'd1) $display("FAIL ipv4_drop got=%0d required=1", rx_drop_cnt); else pass_cnt++;
        build(16'h88F7, 4'h2, 4'h1, 64'd5, rnd80(), 16'd7, rnd80());
        drive(60, rnd80(), 0, 1, 0, 0);
        @(negedge clk);
        total_cnt++;
        if (rx_drop_cnt !== 16'd1) $display("FAIL version_drop got=%0d required=1", rx_drop_cnt); else pass_cnt++;
        build(16'h88F7, 4'h2, 4'h2, 64'd5, rnd80(), 16'd7, rnd80());
        drive(50, rnd80(), 0, 0, 0, 0);
        @(negedge clk);
        total_cnt++;
        if (rx_drop_cnt !== 16'd2) $display("FAIL runt_drop got=%0d required=2", rx_drop_cnt); else pass_cnt++;
        build(16'h88F7, 4'h2, 4'h2, 64'd5, rnd80(), 16'd7, rnd80());
        drive(60, rnd80(), 1, 0, 0, 0);
        @(negedge clk);
        total_cnt++;
        if (rx_drop_cnt !== 16'd3) $display("FAIL err_drop got=%0d required=3", rx_drop_cnt); else pass_cnt++;
        idle(3);
        total_cnt++;
        if (rx_count !== rx0) $display("FAIL bad_no_desc got=%0d required=%0d", rx_count, rx0); else pass_cnt++;
    endtask

    task automatic test_sof_abort();
        logic [431:0] d;
        int rx0;
        rx0 = rx_count;
        gptp_rv_ready = 1'b1;
        good_frame(rnd80(), 4'h2, d);
        drive(30, rnd80(), 0, 0, 1, 0);
        good_frame(rnd80(), 4'hb, d);
        exp_q.push_back(d);
        drive(58, d[431:352], 0, 1, 0, 0);
        idle(4);
        total_cnt++;
        if (rx_count - rx0 !== 1) $display("FAIL abort_count got=%0d required=1", rx_count - rx0); else pass_cnt++;
        total_cnt++;
        if (rx_drop_cnt !== 16'd3) $display("FAIL abort_drop got=%0d required=3", rx_drop_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [431:0] d;
        int rx0;
        gptp_rv_ready = 1'b0;
        good_frame(rnd80(), 4'h2, d);
        drive(58, d[431:352], 0, 0, 0, 0);   // left pending; reset must clear it
        good_frame(rnd80(), 4'h2, d);
        drive(41, d[431:352], 0, 0, 1, 0);
        reset = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (gptp_rv_vaild !== 1'b0) $display("FAIL rstmid_valid got=%b required=0", gptp_rv_vaild); else pass_cnt++;
        total_cnt++;
        if (gptp_rv_data !== 432'd0) $display("FAIL rstmid_data got=%h required=0", gptp_rv_data); else pass_cnt++;
        total_cnt++;
        if (rx_drop_cnt !== 16'd0) $display("FAIL rstmid_drop got=%0d required=0", rx_drop_cnt); else pass_cnt++;
        idle(2);
        reset = 1'b0;
        idle(2);
        rx0 = rx_count;
        gptp_rv_ready = 1'b1;
        good_frame(rnd80(), 4'h2, d);
        exp_q.push_back(d);
        drive(58, d[431:352], 0, 1, 0, 0);
        idle(4);
        total_cnt++;
        if (rx_count - rx0 !== 1) $display("FAIL rstmid_count got=%0d required=1", rx_count - rx0); else pass_cnt++;
        total_cnt++;
        if (rx_drop_cnt !== 16'd0) $display("FAIL rstmid_drop_after got=%0d required=0", rx_drop_cnt); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_pdelay_req();
        test_back_to_back();
        test_backpressure();
        test_bad_frames();
        test_sof_abort();
        test_reset_mid();
        idle(4);
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_empty got=%0d required=0", exp_q.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
